// File: rtl/cnn_pkg.sv
// Shared types for the CNN layer DMA movers (load_block / store_block).
package cnn_pkg;

    localparam int WORD_W = 16;
    localparam int ADDR_W = 16;

    typedef logic signed [WORD_W-1:0] word_t;
    typedef logic [ADDR_W-1:0]        addr_t;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        DONE
    } store_state_t;

endpackage

// File: rtl/store_block.sv
// Drains up to MAX_WORDS words from a layer buffer to the DMA write port at base+idx.
// First write is valid one cycle after start; a word is held until dmaReady accepts it.
module store_block
    import cnn_pkg::*;
#(
    parameter int MAX_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] size,
    input  addr_t       address,
    input  word_t       in [0:MAX_WORDS-1],
    input  logic        dmaReady,
    output addr_t       dmaAddr,
    output word_t       dmaData,
    output logic        dmaWrite,
    output logic        done
);

    localparam int IW = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
    typedef logic [IW-1:0] idx_t;

    store_state_t state_q;
    addr_t        base_q;
    idx_t         last_q;
    idx_t         idx_q;
    addr_t        dmaAddr_q;
    word_t        dmaData_q;
    logic         dmaWrite_q;
    logic         done_q;

    logic         clamp_d;
    logic         empty_d;
    idx_t         last_d;
    idx_t         idx_d;

    // last_q holds len-1, so the index never needs the extra bit len itself would.
    always_comb begin
        clamp_d = (32'(size) > 32'(MAX_WORDS));
        empty_d = (size == 16'd0);
        last_d  = clamp_d ? idx_t'(MAX_WORDS - 1) : idx_t'(size - 16'd1);
        idx_d   = idx_q + idx_t'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            base_q     <= '0;
            last_q     <= '0;
            idx_q      <= '0;
            dmaAddr_q  <= '0;
            dmaData_q  <= '0;
            dmaWrite_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    dmaWrite_q <= 1'b0;
                    done_q     <= 1'b0;
                    if (enable) begin
                        base_q <= address;
                        last_q <= last_d;
                        idx_q  <= '0;
                        if (empty_d) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q    <= WRITE;
                            dmaWrite_q <= 1'b1;
                            dmaAddr_q  <= address;
                            dmaData_q  <= in[0];
                        end
                    end
                end
                WRITE: begin
                    // An abort still lets the DMA take the word presented this cycle.
                    if (!enable) begin
                        state_q    <= IDLE;
                        dmaWrite_q <= 1'b0;
                    end else if (dmaReady) begin
                        if (idx_q == last_q) begin
                            state_q    <= DONE;
                            dmaWrite_q <= 1'b0;
                            done_q     <= 1'b1;
                        end else begin
                            idx_q     <= idx_d;
                            dmaAddr_q <= base_q + addr_t'(idx_d);
                            dmaData_q <= in[idx_d];
                        end
                    end
                end
                DONE: begin
                    if (!enable) begin
                        state_q <= IDLE;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    dmaWrite_q <= 1'b0;
                    done_q     <= 1'b0;
                end
            endcase
        end
    end

    assign dmaAddr  = dmaAddr_q;
    assign dmaData  = dmaData_q;
    assign dmaWrite = dmaWrite_q;
    assign done     = done_q;

endmodule

// File: tb/tb_store_block.sv
// Directed bench for store_block with a write-queue scoreboard and literal spot checks.
module tb_store_block;

    localparam int MW = 1024;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               enable;
    logic               dmaReady;
    logic [15:0]        size;
    logic [15:0]        address;
    logic signed [15:0] mem [0:MW-1];
    logic [15:0]        dmaAddr;
    logic signed [15:0] dmaData;
    logic               dmaWrite;
    logic               done;

    int total = 0;
    int bad   = 0;
    int nwr   = 0;
    int base;
    int dcyc;

    logic [15:0]        log_addr [0:2047];
    logic signed [15:0] log_data [0:2047];
    logic [15:0]        exp_addr_q [$];
    logic signed [15:0] exp_data_q [$];

    logic               pv_w = 1'b0;
    logic               pv_r = 1'b0;
    logic [15:0]        pv_a = '0;
    logic signed [15:0] pv_d = '0;

    always #5 clk = ~clk;

    store_block #(.MAX_WORDS(MW)) dut (
        .clk      (clk),
        .reset    (rst_n),
        .enable   (enable),
        .size     (size),
        .address  (address),
        .in       (mem),
        .dmaReady (dmaReady),
        .dmaAddr  (dmaAddr),
        .dmaData  (dmaData),
        .dmaWrite (dmaWrite),
        .done     (done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Model: a block of size s at base b is the word list (b+i mod 2^16, mem[i]) for i < min(s, MW).
    task automatic expect_block(input int sz, input logic [15:0] ad);
        int n;
        n = (sz > MW) ? MW : sz;
        for (int i = 0; i < n; i++) begin
            exp_addr_q.push_back(ad + 16'(i));
            exp_data_q.push_back(mem[i]);
        end
    endtask

    // Scoreboard: every accepted write must be the next word of the model, stalls must hold.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("write_excl_done", 32'(dmaWrite & done), 32'd0);
            if (pv_w && !pv_r && dmaWrite) begin
                check("hold_addr", 32'(dmaAddr), 32'(pv_a));
                check("hold_data", 32'(dmaData), 32'(pv_d));
            end
            if (dmaWrite && dmaReady) begin
                if (exp_addr_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_write: got addr %0h, want no write", dmaAddr);
                end else begin
                    check("wr_addr", 32'(dmaAddr), 32'(exp_addr_q.pop_front()));
                    check("wr_data", dmaData, exp_data_q.pop_front());
                end
                if (nwr < 2048) begin
                    log_addr[nwr] = dmaAddr;
                    log_data[nwr] = dmaData;
                end
                nwr++;
            end
            pv_w = dmaWrite;
            pv_r = dmaReady;
            pv_a = dmaAddr;
            pv_d = dmaData;
        end else begin
            pv_w = 1'b0;
        end
    end

    // Called #1 after an edge; cycle c=1 is the cycle right after the start edge.
    task automatic run_block(input int sz, input logic [15:0] ad, input int st_from,
                             input int st_len, input int abort_at, input int budget,
                             output int done_at);
        expect_block(sz, ad);
        size     = sz[15:0];
        address  = ad;
        enable   = 1'b1;
        dmaReady = 1'b1;
        done_at  = -1;
        @(posedge clk);
        for (int c = 1; c <= budget; c++) begin
            #1;
            size     = 16'hABCD;
            address  = 16'h5555;
            dmaReady = !(c >= st_from && c < st_from + st_len);
            if (c == abort_at) enable = 1'b0;
            if (done) begin
                done_at = c;
                break;
            end
            @(posedge clk);
        end
    endtask

    task automatic finish_block();
        enable = 1'b0;
        @(posedge clk);
        #1;
        check("done_fall", 32'(done), 32'd0);
        check("idle_nowrite", 32'(dmaWrite), 32'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        enable   = 1'b0;
        dmaReady = 1'b1;
        size     = '0;
        address  = '0;
        for (int i = 0; i < MW; i++) mem[i] = 16'(i * 7 - 300);
        mem[0] = 16'sd5;
        mem[1] = -16'sd3;
        mem[2] = 16'sd7;
        mem[3] = 16'sd0;

        #12;
        check("rst_dmaWrite", 32'(dmaWrite), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_dmaAddr", 32'(dmaAddr), 32'd0);
        check("rst_dmaData", dmaData, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic 4-word block
        base = nwr;
        run_block(4, 16'h0010, 0, 0, 0, 40, dcyc);
        check("basic_done_cyc", dcyc, 5);
        check("basic_nwr", nwr - base, 4);
        check("basic_a0", 32'(log_addr[base]), 32'h0010);
        check("basic_d1", log_data[base + 1], -3);
        check("basic_d2", log_data[base + 2], 7);
        check("basic_a3", 32'(log_addr[base + 3]), 32'h0013);
        finish_block();

        // Two stall cycles on the second word
        base = nwr;
        run_block(4, 16'h0010, 2, 2, 0, 40, dcyc);
        check("stall_done_cyc", dcyc, 7);
        check("stall_nwr", nwr - base, 4);
        check("stall_a1", 32'(log_addr[base + 1]), 32'h0011);
        check("stall_d1", log_data[base + 1], -3);
        finish_block();

        // Empty block
        base = nwr;
        run_block(0, 16'h0040, 0, 0, 0, 40, dcyc);
        check("zero_done_cyc", dcyc, 1);
        check("zero_nwr", nwr - base, 0);
        finish_block();

        // Address wrap
        base = nwr;
        run_block(3, 16'hFFFE, 0, 0, 0, 40, dcyc);
        check("wrap_done_cyc", dcyc, 4);
        check("wrap_a0", 32'(log_addr[base]), 32'hFFFE);
        check("wrap_a1", 32'(log_addr[base + 1]), 32'hFFFF);
        check("wrap_a2", 32'(log_addr[base + 2]), 32'h0000);
        finish_block();

        // Oversized request clamps to MW words
        base = nwr;
        run_block(1030, 16'h0100, 0, 0, 0, 1100, dcyc);
        check("clamp_done_cyc", dcyc, 1025);
        check("clamp_nwr", nwr - base, 1024);
        check("clamp_last_a", 32'(log_addr[base + 1023]), 32'h04FF);
        check("clamp_last_d", log_data[base + 1023], 6861);
        check("clamp_queue_empty", exp_addr_q.size(), 0);
        finish_block();

        // Abort after two accepted words
        base = nwr;
        run_block(4, 16'h0020, 0, 0, 2, 8, dcyc);
        check("abort_no_done", dcyc, -1);
        check("abort_nwr", nwr - base, 2);
        check("abort_dmaWrite", 32'(dmaWrite), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        exp_addr_q.delete();
        exp_data_q.delete();

        // Asynchronous reset mid-block, then restart from in[0]
        run_block(4, 16'h0020, 0, 0, 0, 2, dcyc);
        #3;
        rst_n  = 1'b0;
        enable = 1'b0;
        #1;
        check("rstmid_dmaWrite", 32'(dmaWrite), 32'd0);
        check("rstmid_done", 32'(done), 32'd0);
        check("rstmid_dmaAddr", 32'(dmaAddr), 32'd0);
        check("rstmid_dmaData", dmaData, 32'd0);
        exp_addr_q.delete();
        exp_data_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rstrel_nowrite", 32'(dmaWrite), 32'd0);
        base = nwr;
        run_block(2, 16'h0030, 0, 0, 0, 40, dcyc);
        check("restart_done_cyc", dcyc, 3);
        check("restart_a0", 32'(log_addr[base]), 32'h0030);
        check("restart_d0", log_data[base], 5);

        // Enable held after done: no retrigger
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("hold_done", 32'(done), 32'd1);
            check("hold_nowrite", 32'(dmaWrite), 32'd0);
        end
        check("hold_nwr", nwr - base, 2);
        finish_block();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/store_block.md
# store_block

Writer counterpart of `load_block`: drains a block of up to `MAX_WORDS` signed 16-bit words from a layer-side buffer into memory through the `DMA` write port, one word per accepted cycle, at consecutive addresses from a base. Sits between a layer engine (pool/conv output buffer) and the shared `DMA`. The layer only supplies a buffer, a size, and a base address; it no longer drives `writeAddr`/`writeOut` word by word.

## Interface
Parameters:
- `MAX_WORDS`, 1024: buffer depth; upper bound on block size.
- `WORD_W`, 16: data word width.
- `ADDR_W`, 16: DMA address width.

Ports:
- `clk` input 1: single clock; everything is on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `enable` input 1: level request. Rising into IDLE starts a block. Dropping mid-block aborts it.
- `size` input 16: number of words to write. Sampled at start.
- `address` input ADDR_W: base memory address. Sampled at start.
- `in` input signed WORD_W × [0:MAX_WORDS-1]: source buffer. Must be held stable from start until `done`.
- `dmaReady` input 1: DMA accepts the current word this cycle.
- `dmaAddr` output ADDR_W: write address.
- `dmaData` output WORD_W: write data.
- `dmaWrite` output 1: write request; feeds the DMA enable, with RW=0.
- `done` output 1: block completed.

## Operation
- States: IDLE, WRITE, DONE.
- IDLE: `enable`=1 latches `address` into `base` and `min(size, MAX_WORDS)` into `len`, and clears `idx`.
  - `len`==0: go to DONE.
  - Otherwise: go to WRITE.
- WRITE:
  - `dmaWrite`=1, `dmaAddr`=`base`+`idx` (mod 2^ADDR_W, wraps silently), `dmaData`=`in[idx]`.
  - A word is accepted when `dmaWrite`&&`dmaReady`. On accept, `idx`++.
  - Accept with `idx`==`len`-1: go to DONE.
  - Without `dmaReady`, hold address and data unchanged.
- DONE: `done`=1, `dmaWrite`=0. Stay until `enable`=0, then go to IDLE. This level handshake means no retrigger while `enable` is held.
- `enable`=0 during WRITE: abort. Go to IDLE next edge, `dmaWrite` drops, `done` never asserts, and the words already accepted remain written.
- `size` > `MAX_WORDS`: clamp; exactly `MAX_WORDS` words are written.
- Changes on `size`/`address` after start are ignored.

## Timing
- All outputs are registered.
- Reset values: `dmaWrite`=0, `done`=0, `dmaAddr`=0, `dmaData`=0, state IDLE, `idx`=0.
- `reset` asserted mid-block takes effect immediately (asynchronous). No further writes after release until a new `enable` arrives in IDLE.
- Start latency: `enable` sampled high at edge k gives the first `dmaWrite` valid after edge k.
- Throughput: one word per cycle while `dmaReady`=1.
- With `dmaReady` tied high, N words occupy N consecutive cycles, and `done` rises the cycle after the last accept. Total is N+1 cycles from start edge to `done`.
- `size`=0: `done` rises one cycle after start; `dmaWrite` never asserts.
- `done` falls the cycle after `enable` is sampled low.
- A new start is possible on the following edge (IDLE).

## Structure
- Shared package `cnn_pkg` holds:
  - `WORD_W` and `ADDR_W` constants;
  - `word_t` (signed `[WORD_W-1:0]`) and `addr_t` typedefs;
  - `store_state_t` enum {IDLE, WRITE, DONE}.
- The `load_block` side should import the same package.
- No sub-module. Single FSM plus an index counter; the buffer mux is inferred.

## Test plan
- Reset low; `enable`=1, `size`=4, `address`=0x0010, `in`={5,-3,7,0}, `dmaReady`=1 -> writes (0x10,5), (0x11,-3), (0x12,7), (0x13,0) on four consecutive cycles; `done`=1 on the fifth; `done`=0 one cycle after `enable`=0.
- Same block with `dmaReady` low for 2 cycles on the second word -> `dmaAddr`=0x11 and `dmaData`=-3 held for 3 cycles; no skipped or duplicated writes; `done` delayed by 2 cycles.
- `size`=0 -> no `dmaWrite`; `done` one cycle after start. `size`=3, `address`=0xFFFE -> addresses 0xFFFE, 0xFFFF, 0x0000.
- `size`=1030 with `MAX_WORDS`=1024 -> exactly 1024 writes, last address base+1023, then `done`.
- `enable` dropped after 2 of 4 words -> exactly 2 writes; `dmaWrite`=0 next cycle; `done` stays 0. `reset` pulsed low mid-block -> outputs immediately 0; a restart afterwards writes from `in[0]`.
- `enable` held high after `done` for 10 cycles -> no second block; `done` stays 1 throughout.
